// File: rtl/hfrv_debug_tap.sv
// Multi-channel debug byte capture: snoops CPU byte writes to a block of word-spaced
// channel addresses, buffers each channel in a FIFO and merges them round-robin onto one stream.
module hfrv_debug_tap #(
    parameter int          CH_COUNT  = 4,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hf00000d0,
    localparam int         CH_W      = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         bus_addr,
    input  logic [31:0]         bus_data,
    input  logic [3:0]          bus_we,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic [CH_W-1:0]     out_chan,
    output logic                out_eol,
    output logic [CH_COUNT-1:0] ovf,
    input  logic                ovf_clr,
    output logic [15:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]       wptr_q [CH_COUNT];
    logic [PW-1:0]       wptr_d [CH_COUNT];
    logic [PW-1:0]       rptr_q [CH_COUNT];
    logic [PW-1:0]       rptr_d [CH_COUNT];
    logic [7:0]          mem_q  [CH_COUNT][DEPTH];
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_data_q, out_data_d;
    logic [CH_W-1:0]     out_chan_q, out_chan_d;
    logic                out_eol_q, out_eol_d;
    logic [CH_COUNT-1:0] ovf_q, ovf_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [CH_W-1:0]     rr_q, rr_d;

    logic [29:0]         off_s;
    logic                hit_s;
    logic [CH_W-1:0]     hit_ch_s;
    logic [7:0]          byte_s;
    logic [CH_COUNT-1:0] empty_s;
    logic [CH_COUNT-1:0] full_s;
    logic                push_s;
    logic                drop_s;
    logic                load_s;
    logic                found_s;
    logic [CH_W-1:0]     grant_s;
    logic                unused_s;

    assign unused_s = ^bus_addr[1:0];

    // Address decode, byte-lane select and per-FIFO status from pre-edge pointers.
    always_comb begin
        off_s    = bus_addr[31:2] - BASE_ADDR[31:2];
        hit_s    = (bus_we != 4'b0000) && (off_s < 30'(CH_COUNT));
        hit_ch_s = CH_W'(off_s);
        if (bus_we[0]) begin
            byte_s = bus_data[7:0];
        end else if (bus_we[1]) begin
            byte_s = bus_data[15:8];
        end else if (bus_we[2]) begin
            byte_s = bus_data[23:16];
        end else begin
            byte_s = bus_data[31:24];
        end
        for (int k = 0; k < CH_COUNT; k++) begin
            empty_s[k] = (wptr_q[k] == rptr_q[k]);
            full_s[k]  = (wptr_q[k][AW] != rptr_q[k][AW]) &&
                         (wptr_q[k][AW-1:0] == rptr_q[k][AW-1:0]);
        end
        push_s = hit_s && !full_s[hit_ch_s];
        drop_s = hit_s && full_s[hit_ch_s];
    end

    // Round-robin pick of the first non-empty channel after the last grant.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        for (int i = 1; i <= CH_COUNT; i++) begin
            if (!found_s && !empty_s[(int'(rr_q) + i) % CH_COUNT]) begin
                found_s = 1'b1;
                grant_s = CH_W'((int'(rr_q) + i) % CH_COUNT);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state: output register load, pointer updates, overflow bookkeeping.
    always_comb begin
        load_s      = !out_valid_q || out_ready;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_eol_d   = out_eol_q;
        rr_d        = rr_q;
        ovf_d       = ovf_q;
        drop_cnt_d  = drop_cnt_q;
        for (int k = 0; k < CH_COUNT; k++) begin
            wptr_d[k] = wptr_q[k];
            rptr_d[k] = rptr_q[k];
        end
        if (load_s) begin
            out_valid_d = found_s;
            if (found_s) begin
                out_data_d      = mem_q[grant_s][rptr_q[grant_s][AW-1:0]];
                out_chan_d      = grant_s;
                out_eol_d       = (mem_q[grant_s][rptr_q[grant_s][AW-1:0]] == 8'h0a);
                rptr_d[grant_s] = rptr_q[grant_s] + PW'(1);
                rr_d            = grant_s;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        if (push_s) begin
            wptr_d[hit_ch_s] = wptr_q[hit_ch_s] + PW'(1);
        end else begin
            wptr_d[hit_ch_s] = wptr_q[hit_ch_s];
        end
        // A same-cycle clear outranks a drop, so the drop leaves no trace.
        if (ovf_clr) begin
            ovf_d      = '0;
            drop_cnt_d = 16'h0000;
        end else if (drop_s) begin
            ovf_d[hit_ch_s] = 1'b1;
            drop_cnt_d      = (drop_cnt_q == 16'hffff) ? 16'hffff : drop_cnt_q + 16'h0001;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_chan_q  <= '0;
            out_eol_q   <= 1'b0;
            ovf_q       <= '0;
            drop_cnt_q  <= 16'h0000;
            rr_q        <= CH_W'(CH_COUNT - 1);
            for (int k = 0; k < CH_COUNT; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_eol_q   <= out_eol_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            rr_q        <= rr_d;
            for (int k = 0; k < CH_COUNT; k++) begin
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
            end
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[hit_ch_s][wptr_q[hit_ch_s][AW-1:0]] <= byte_s;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_eol   = out_eol_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_hfrv_debug_tap.sv
// Randomized and directed bench for hfrv_debug_tap against a queue-based behavioural model.
module tb_hfrv_debug_tap;
    localparam int          CH    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hf00000d0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] bus_addr = 32'h0;
    logic [31:0] bus_data = 32'h0;
    logic [3:0]  bus_we = 4'b0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_eol;
    logic [3:0]  ovf;
    logic        ovf_clr = 1'b0;
    logic [15:0] drop_cnt;

    int n_chk = 0;
    int n_bad = 0;

    // Model: per-channel circular buffers plus the visible output word.
    logic [7:0]  q_buf [CH][DEPTH];
    int          q_head [CH];
    int          q_cnt  [CH];
    bit          m_valid;
    logic [7:0]  m_data;
    int          m_chan;
    int          m_last;
    logic [3:0]  m_ovf;
    int          m_drop;

    hfrv_debug_tap #(.CH_COUNT(CH), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_we(bus_we), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .out_eol(out_eol),
        .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            q_head[k] = 0;
            q_cnt[k]  = 0;
        end
        m_valid = 0; m_data = 8'h00; m_chan = 0; m_last = CH - 1;
        m_ovf = 4'b0000; m_drop = 0;
    endtask

    task automatic model_edge();
        bit          hit;
        bit          full_pre;
        int          k;
        int          c;
        logic [31:0] off;
        logic [7:0]  b;
        off = (bus_addr - BASE) >> 2;
        hit = (bus_we != 4'b0000) && (off < CH);
        k   = hit ? int'(off) : 0;
        b   = bus_data[31:24];
        for (int l = 3; l >= 0; l--) if (bus_we[l]) b = bus_data[8*l +: 8];
        full_pre = (q_cnt[k] == DEPTH);
        if (!m_valid || out_ready) begin
            m_valid = 0;
            for (int i = 1; i <= CH; i++) begin
                c = (m_last + i) % CH;
                if (!m_valid && q_cnt[c] > 0) begin
                    m_valid = 1;
                    m_data  = q_buf[c][q_head[c]];
                    m_chan  = c;
                    m_last  = c;
                    q_head[c] = (q_head[c] + 1) % DEPTH;
                    q_cnt[c]--;
                end
            end
        end
        if (hit) begin
            if (full_pre) begin
                if (!ovf_clr) begin
                    m_ovf[k] = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end else begin
                q_buf[k][(q_head[k] + q_cnt[k]) % DEPTH] = b;
                q_cnt[k]++;
            end
        end
        if (ovf_clr) begin
            m_ovf = 4'b0000;
            m_drop = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_chan", out_chan, m_chan);
            chk("out_eol", out_eol, m_data == 8'h0a);
        end
        chk("ovf", ovf, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus_addr = a; bus_data = d; bus_we = we;
        tick();
        bus_we = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_data"}, out_data, 8'h00);
        chk({tag, "_chan"}, out_chan, 2'd0);
        chk({tag, "_eol"}, out_eol, 1'b0);
        chk({tag, "_ovf"}, ovf, 4'b0000);
        chk({tag, "_drop"}, drop_cnt, 16'h0000);
    endtask

    initial begin
        int k;
        model_reset();
        #12;
        check_reset_outputs("rst");
        reset_n = 1'b1;

        // 1: "Hi\n" on ch0, first valid one cycle after the first write.
        out_ready = 1'b1;
        put(BASE, 32'h48, 4'b0001);
        chk("t1_lat0", out_valid, 1'b0);
        put(BASE, 32'h69, 4'b0001);
        chk("t1_first", out_data, 8'h48);
        put(BASE, 32'h0a, 4'b0001);
        idle(4);

        // 2: overflow ch1 with the consumer stalled, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) put(BASE + 32'd4, 32'(i), 4'b0001);
        chk("t2_ovf", ovf, 4'b0010);
        chk("t2_drop", drop_cnt, 16'd1);
        out_ready = 1'b1;
        idle(DEPTH + 4);

        // 3: round-robin between ch0/ch2/ch3.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) put(BASE, 32'h30 + 32'(i), 4'b0001);
        for (int i = 0; i < 3; i++) put(BASE + 32'd8, 32'h40 + 32'(i), 4'b0001);
        put(BASE + 32'd12, 32'h50, 4'b0001);
        out_ready = 1'b1;
        idle(10);

        // 4: toggled ready while writing ch3.
        for (int i = 0; i < 12; i++) begin
            out_ready = i[1];
            put(BASE + 32'd12, 32'h60 + 32'(i), 4'b0001);
        end
        out_ready = 1'b1;
        idle(6);

        // 5: out-of-range and read ignored; lane-2 byte write.
        put(BASE + 32'd16, 32'h11223344, 4'b1111);
        put(BASE, 32'h55667788, 4'b0000);
        put(BASE + 32'd3, 32'h00410000, 4'b0100);
        chk("t5_lat", out_valid, 1'b0);
        tick();
        chk("t5_lane", out_data, 8'h41);
        idle(3);

        // 6: async reset mid-drain, then clear colliding with a drop.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(BASE + 32'd8, 32'h70 + 32'(i), 4'b0001);
        out_ready = 1'b1;
        tick();
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(4);
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) put(BASE + 32'd8, 32'(i), 4'b0001);
        ovf_clr = 1'b1;
        put(BASE + 32'd8, 32'hee, 4'b0001);
        ovf_clr = 1'b0;
        chk("t6_ovf", ovf, 4'b0000);
        chk("t6_drop", drop_cnt, 16'h0000);
        put(BASE + 32'd8, 32'hef, 4'b0001);
        out_ready = 1'b1;
        idle(DEPTH + 4);

        // Random traffic: a stall-heavy phase then a flowing phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                out_ready = ($urandom_range(0, 9) < (ph == 0 ? 3 : 8));
                ovf_clr   = ($urandom_range(0, 99) == 0);
                k = $urandom_range(0, 7);
                if (k < 6)       bus_addr = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
                else if (k == 6) bus_addr = $urandom;
                else             bus_addr = BASE - 32'd4;
                bus_data = $urandom;
                bus_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
                tick();
            end
        end
        bus_we = 4'b0000; ovf_clr = 1'b0; out_ready = 1'b1;
        idle(CH * DEPTH + 4);
        chk("drained", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
